// File: rtl/count_delta_streamer.sv
// rtl/count_delta_streamer.sv - snapshots two 64-bit counts and streams their deltas as 17-byte frames
module count_delta_streamer (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] count0,
  input  logic [63:0] count1,
  input  logic        sample,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t      state;
  logic [63:0] prev0, prev1;
  logic [63:0] delta0, delta1;
  logic [3:0]  seq;
  logic        ovr;
  logic [3:0]  idx;
  logic [7:0]  hdr;
  logic [63:0] cur_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      prev0  <= '0;
      prev1  <= '0;
      delta0 <= '0;
      delta1 <= '0;
      seq    <= '0;
      ovr    <= 1'b0;
      idx    <= '0;
      hdr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample) begin
            // Modulo-2^64 subtraction yields the forward distance across counter wrap.
            delta0 <= count0 - prev0;
            delta1 <= count1 - prev1;
            prev0  <= count0;
            prev1  <= count1;
            hdr    <= {ovr, 3'b000, seq};
            ovr    <= 1'b0;
            seq    <= seq + 4'd1;
            state  <= HEADER;
          end
        end
        HEADER: begin
          if (sample) ovr <= 1'b1;
          if (out_ready) begin
            idx   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          // A request on the final-byte edge is still a drop: the FSM is not IDLE yet.
          if (sample) ovr <= 1'b1;
          if (out_ready) begin
            if (idx == 4'd15) state <= IDLE;
            else              idx   <= idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur_word  = idx[3] ? delta1 : delta0;
  assign out_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  assign out_last  = (state == DATA) && (idx == 4'd15);

  always_comb begin
    out_data = 8'h00;
    case (state)
      HEADER:  out_data = hdr;
      DATA:    out_data = cur_word[{idx[2:0], 3'b000} +: 8];
      default: out_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_count_delta_streamer.sv
// tb/tb_count_delta_streamer.sv - table-driven scoreboard bench for count_delta_streamer
module tb_count_delta_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] count0, count1;
  logic        sample;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] q[$];

  typedef struct {
    logic [63:0] c0;
    logic [63:0] c1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [7:0]  hdr;
    int          mode;
    bit          poke;
  } vec_t;

  vec_t vecs[8];

  count_delta_streamer dut (
    .clk(clk), .reset(reset), .count0(count0), .count1(count1),
    .sample(sample), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] hdr, input logic [63:0] d0, input logic [63:0] d1);
    logic [63:0] w;
    q.push_back({hdr, 1'b0});
    for (int b = 0; b < 16; b++) begin
      w = (b < 8) ? d0 : d1;
      q.push_back({w[8*(b%8) +: 8], (b == 15)});
    end
  endtask

  task automatic start_frame(input logic [63:0] c0, input logic [63:0] c1, input logic [7:0] hdr,
                             input logic [63:0] d0, input logic [63:0] d1);
    count0 = c0;
    count1 = c1;
    sample = 1'b1;
    step();
    sample = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", out_valid, 1);
    chk("start_header", out_data, hdr);
    push_frame(hdr, d0, d1);
  endtask

  task automatic drain(input int mode, input bit poke, input int stop_after);
    int         pops = 0;
    int         cyc = 0;
    bit         stalled = 0;
    bit         poked = 0;
    logic       r;
    logic [7:0] held_d;
    logic       held_l;
    logic [8:0] e;
    logic [3:0] pat;
    pat = 4'b1001;
    while (q.size() > 0 && cyc < 400 && !(stop_after >= 0 && pops >= stop_after)) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[3 - (cyc % 4)];
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      chk("valid_in_frame", out_valid, 1);
      if (stalled) begin
        chk("stall_data", out_data, held_d);
        chk("stall_last", out_last, held_l);
      end
      if (r) begin
        e = q.pop_front();
        chk("byte", out_data, e[8:1]);
        chk("last", out_last, e[0]);
        pops++;
        stalled = 0;
      end else begin
        stalled = 1;
        held_d  = out_data;
        held_l  = out_last;
      end
      if (poke && !poked && pops == 8) begin
        sample = 1'b1;
        poked  = 1;
      end
      step();
      sample = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= 400) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 bytes left", q.size());
    end
    if (stop_after < 0) begin
      chk("end_busy", busy, 0);
      chk("end_valid", out_valid, 0);
      chk("end_last", out_last, 0);
    end
  endtask

  initial begin
    vecs[0] = '{64'h10, 64'h20, 64'h10, 64'h20, 8'h00, 0, 0};
    vecs[1] = '{64'h18, 64'h25, 64'h08, 64'h05, 8'h01, 0, 0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h1_0000_0025,
                64'hFFFF_FFFF_FFFF_FFD8, 64'h1_0000_0000, 8'h02, 0, 0};
    vecs[3] = '{64'h5, 64'h1_0000_1259, 64'h15, 64'h1234, 8'h03, 1, 0};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h0123_4567_89AB_CDEA, 64'hFEDC_BA97_7654_1FB7, 8'h04, 2, 0};
    vecs[5] = '{64'h0123_4567_89AB_CEEF, 64'hFEDC_BA98_7654_3210, 64'h100, 64'h0, 8'h05, 0, 1};
    vecs[6] = '{64'h0123_4567_89AB_CEF0, 64'hFEDC_BA98_7654_3210, 64'h1, 64'h0, 8'h86, 1, 0};
    vecs[7] = '{64'h0123_4567_89AB_CEF0, 64'hFEDC_BA98_7654_3212, 64'h0, 64'h2, 8'h07, 0, 0};

    reset = 1'b1; count0 = '0; count1 = '0; sample = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 8'h00);
    step();
    step();
    reset = 1'b0;
    step();
    chk("idle_valid", out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      start_frame(vecs[i].c0, vecs[i].c1, vecs[i].hdr, vecs[i].d0, vecs[i].d1);
      drain(vecs[i].mode, vecs[i].poke, -1);
      step();
      chk("gap_idle", busy, 0);
    end

    // Abort mid-frame while byte Idx=5 is being presented.
    start_frame(64'h0123_4567_89AC_0234, 64'hFEDC_BA98_7654_3222, 8'h08, 64'h3344, 64'h10);
    drain(0, 0, 6);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", out_data, 8'h00);
    reset = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 8'h00);
    chk("abort_busy", busy, 0);
    q.delete();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_idle", out_valid, 0);
    start_frame(64'h77, 64'h99, 8'h00, 64'h77, 64'h99);
    drain(2, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/count_delta_streamer.md
# count_delta_streamer

Consumes the two 64-bit count outputs of the double counter stage and, on each sample request, reports how far each count has advanced since the previous sample. Each report is a 17-byte frame: one header byte, then two 64-bit deltas. The frame leaves on an 8-bit valid/ready byte stream toward the host/UART-side logic. The block is the stage directly downstream of the double counter.

## Interface
- No parameters; widths are fixed (64-bit counts, 8-bit stream).
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Count0  input  64  first counter value from double counter.
- Count1  input  64  second counter value from double counter.
- Sample  input  1  snapshot request; level, sampled on every rising edge.
- Out_Ready  input  1  downstream can take a byte this cycle.
- Out_Valid  output  1  Out_Data holds a valid byte.
- Out_Data  output  8  current frame byte.
- Out_Last  output  1  high with the final byte of a frame.
- Busy  output  1  a frame is in progress (state not IDLE).

## Operation
- State registers:
  - Prev0/Prev1: 64-bit, previous snapshot.
  - Delta0/Delta1: 64-bit.
  - Seq: 4-bit.
  - Ovr: 1-bit sticky.
  - Idx: 4-bit byte index.
  - FSM: IDLE, HEADER, DATA.
- IDLE with Sample=1 at an edge:
  - Delta0 <= Count0 - Prev0 and Delta1 <= Count1 - Prev1, both modulo 2^64 (wrap-around gives the correct forward distance).
  - Prev0 <= Count0; Prev1 <= Count1.
  - Header byte is latched as {Ovr, 3'b000, Seq}.
  - Ovr is then cleared and Seq increments (15 wraps to 0).
  - FSM -> HEADER.
- HEADER: Out_Data = header byte. On transfer, Idx <= 0 and FSM -> DATA.
- DATA: bytes are sent least-significant byte first.
  - Idx 0-7 carry Delta0[8*Idx+7 : 8*Idx].
  - Idx 8-15 carry Delta1[8*(Idx-8)+7 : 8*(Idx-8)].
  - Out_Last = 1 only when Idx = 15.
  - A transfer at Idx 15 sends FSM -> IDLE; otherwise Idx increments.
- Sample=1 at any edge where FSM is not IDLE:
  - The request is dropped and Ovr <= 1.
  - This includes the edge of the final byte transfer.
- Ovr set and cleared at the same edge cannot occur, since clearing happens only in IDLE.
- First frame after reset reports the absolute counts, because Prev resets to 0.
- Count0/Count1 are used only at the capture edge; changes after that do not affect the frame in progress.

## Timing
- Reset (async, immediate) values:
  - FSM = IDLE; Out_Valid, Out_Last, Busy = 0; Out_Data = 0x00.
  - Prev0, Prev1, Delta0, Delta1 = 0; Seq = 0; Ovr = 0.
- Reset mid-frame aborts the frame. No partial-frame completion after release.
- Latency: Sample accepted at edge N gives Out_Valid=1 and Busy=1 from just after edge N; the header is presented in cycle N+1.
- Out_Valid = 1 in HEADER and DATA, 0 in IDLE. Outputs are registered or decoded from registered state only.
- Transfer = Out_Valid && Out_Ready at a rising edge.
- While Out_Ready=0: Out_Data, Out_Last and Idx hold stable. Out_Valid never drops mid-frame except on Reset.
- Full-rate frame with Out_Ready held at 1: 17 cycles.
  - Busy falls after the edge of the last transfer.
  - The earliest next accepted Sample is the following edge, i.e. the minimum frame spacing is 18 edges.
- Sample held high continuously: frames start back-to-back with one IDLE cycle between them, and every header has Ovr=1 except the first.

## Test plan
- Reset release, Count0=0x10, Count1=0x20, one Sample pulse, Out_Ready=1 -> bytes 00, 10, 00×7, 20, 00×7; Out_Last on byte 17 only; Busy low after.
- Then Count0=0x18, Count1=0x25, Sample -> header 01; Delta0 bytes 08,00×7; Delta1 bytes 05,00×7.
- Wrap: Prev0=0xFFFF_FFFF_FFFF_FFF0, Count0=0x5 -> Delta0 bytes 15,00×7; Delta1 correct independently.
- Backpressure: Out_Ready toggled 1,0,0,1,… -> each byte held stable while stalled; frame contents identical to the unstalled case; no byte duplicated or skipped.
- Overrun: Sample pulsed during the DATA phase of frame Seq=2 -> no extra frame; next accepted frame header = 0x83; the frame after that has header 0x04.
- Reset asserted at Idx=5 -> Out_Valid=0 and Out_Data=0 immediately; after release, the next frame has header 00 and reports absolute counts.
